ifft_4pt_stream: RTL and testbench

Streaming 4-point inverse FFT (radix-2 DIT, W4^-1 = +j) with 1/4 scaling. It accepts one frequency-domain frame X[0..3] serially over a valid/ready input, computes the inverse transform in one registered step, and emits x[0..3] serially over a valid/ready output. It sits on the return path after the 4-point forward FFT, whose DATA_WIDTH+2 outputs it consumes directly, and restores the original time-domain samples.

---
 rtl/ifft_4pt_stream.sv | 124 ++++++++++++
 tb/tb_ifft_4pt_stream.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_4pt_stream.sv
// Streaming 4-point inverse FFT with 1/4 scaling and valid/ready framing.
// Ports: clk, rst | in_* frame input (X[0..3]) | out_* frame output (x[0..3]) | frame_err.
module ifft_4pt_stream #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH+1:0] in_r,
    input  logic signed [DATA_WIDTH+1:0] in_i,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH+1:0] out_r,
    output logic signed [DATA_WIDTH+1:0] out_i,
    output logic                         out_last,
    output logic                         frame_err
);
    localparam int W = DATA_WIDTH + 2;
    localparam logic signed [W+1:0] RND = 2;

    typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

    state_t state, state_n;
    logic [1:0] in_cnt, out_cnt;
    logic signed [W-1:0] buf_r [4];
    logic signed [W-1:0] buf_i [4];
    logic signed [W-1:0] res_r [4];
    logic signed [W-1:0] res_i [4];
    logic signed [W-1:0] nx_r [4];
    logic signed [W-1:0] nx_i [4];
    logic signed [W+1:0] e_r [4];
    logic signed [W+1:0] e_i [4];
    logic signed [W+1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
    logic in_fire, out_fire;

    // Round half toward +inf, then drop to W bits (result always fits).
    function automatic logic signed [W-1:0] rnd(input logic signed [W+1:0] s);
        logic signed [W+1:0] t;
        t = (s + RND) >>> 2;
        return t[W-1:0];
    endfunction

    assign in_ready  = (state == COLLECT) && !rst;
    assign out_valid = (state == EMIT);
    assign out_last  = (state == EMIT) && (out_cnt == 2'd3);
    assign out_r     = (state == EMIT) ? res_r[out_cnt] : '0;
    assign out_i     = (state == EMIT) ? res_i[out_cnt] : '0;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_n = state;
        unique case (state)
            COLLECT: if (in_fire && in_cnt == 2'd3) state_n = COMPUTE;
            COMPUTE: state_n = EMIT;
            EMIT:    if (out_fire && out_cnt == 2'd3) state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            e_r[k] = buf_r[k];
            e_i[k] = buf_i[k];
        end
        a_r = e_r[0] + e_r[2];
        a_i = e_i[0] + e_i[2];
        b_r = e_r[0] - e_r[2];
        b_i = e_i[0] - e_i[2];
        c_r = e_r[1] + e_r[3];
        c_i = e_i[1] + e_i[3];
        d_r = e_r[1] - e_r[3];
        d_i = e_i[1] - e_i[3];
        // Odd outputs rotate D by +j (inverse twiddle).
        nx_r[0] = rnd(a_r + c_r);
        nx_i[0] = rnd(a_i + c_i);
        nx_r[1] = rnd(b_r - d_i);
        nx_i[1] = rnd(b_i + d_r);
        nx_r[2] = rnd(a_r - c_r);
        nx_i[2] = rnd(a_i - c_i);
        nx_r[3] = rnd(b_r + d_i);
        nx_i[3] = rnd(b_i - d_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            in_cnt    <= '0;
            out_cnt   <= '0;
            frame_err <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                buf_r[k] <= '0;
                buf_i[k] <= '0;
                res_r[k] <= '0;
                res_i[k] <= '0;
            end
        end else begin
            state     <= state_n;
            frame_err <= 1'b0;
            if (in_fire) begin
                if (in_last && in_cnt != 2'd3) begin
                    // Short frame: drop everything gathered so far.
                    in_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    buf_r[in_cnt] <= in_r;
                    buf_i[in_cnt] <= in_i;
                    in_cnt        <= in_cnt + 2'd1;
                    if (!in_last && in_cnt == 2'd3) frame_err <= 1'b1;
                end
            end
            if (state == COMPUTE) begin
                for (int k = 0; k < 4; k++) begin
                    res_r[k] <= nx_r[k];
                    res_i[k] <= nx_i[k];
                end
                out_cnt <= '0;
            end
            if (out_fire) out_cnt <= out_cnt + 2'd1;
        end
    end
endmodule

// File: tb/tb_ifft_4pt_stream.sv
// Self-checking bench for ifft_4pt_stream against a DFT-sum reference model.
// Ports: drives every DUT port; prints FAIL lines and one summary line.
module tb_ifft_4pt_stream;
    localparam int DW = 16;
    localparam int W = DW + 2;

    logic clk = 1'b0;
    logic rst, in_valid, in_last, out_ready;
    logic signed [W-1:0] in_r, in_i;
    logic in_ready, out_valid, out_last, frame_err;
    logic signed [W-1:0] out_r, out_i;

    int total = 0;
    int passed = 0;

    int xr [4];
    int xi [4];
    int ex_r [4];
    int ex_i [4];
    int got_r [4];
    int got_i [4];
    bit got_l [4];
    bit lp [4];

    ifft_4pt_stream #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_last(out_last),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // x[n] = round(sum_k X[k] * j^(k*n) / 4), half toward +inf
    task automatic ref_ifft();
        int sr, si, m;
        for (int n = 0; n < 4; n++) begin
            sr = 0;
            si = 0;
            for (int k = 0; k < 4; k++) begin
                m = (k * n) % 4;
                case (m)
                    0: begin sr += xr[k]; si += xi[k]; end
                    1: begin sr -= xi[k]; si += xr[k]; end
                    2: begin sr -= xr[k]; si -= xi[k]; end
                    default: begin sr += xi[k]; si -= xr[k]; end
                endcase
            end
            ex_r[n] = (sr + 2) >>> 2;
            ex_i[n] = (si + 2) >>> 2;
        end
    endtask

    // Random 16-bit time samples taken through a forward DFT into X.
    task automatic rand_frame();
        int tr [4];
        int ti [4];
        int m;
        for (int n = 0; n < 4; n++) begin
            tr[n] = $urandom_range(0, 65535) - 32768;
            ti[n] = $urandom_range(0, 65535) - 32768;
        end
        for (int k = 0; k < 4; k++) begin
            xr[k] = 0;
            xi[k] = 0;
            for (int n = 0; n < 4; n++) begin
                m = (k * n) % 4;
                case (m)
                    0: begin xr[k] += tr[n]; xi[k] += ti[n]; end
                    1: begin xr[k] += ti[n]; xi[k] -= tr[n]; end
                    2: begin xr[k] -= tr[n]; xi[k] -= ti[n]; end
                    default: begin xr[k] -= ti[n]; xi[k] += tr[n]; end
                endcase
            end
        end
    endtask

    task automatic push(input int r, input int i, input bit last, input bit gaps);
        int n;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_r = r[W-1:0];
        in_i = i[W-1:0];
        in_last = last;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            total++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send(input bit gaps);
        for (int k = 0; k < 4; k++) push(xr[k], xi[k], lp[k], gaps);
    endtask

    task automatic pop(input int n);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        if (!out_valid) begin
            total++;
            $display("FAIL pop_timeout out_valid=%b required 1", out_valid);
        end
        got_r[n] = int'(out_r);
        got_i[n] = int'(out_i);
        got_l[n] = out_last;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic set_last_ok();
        lp[0] = 0; lp[1] = 0; lp[2] = 0; lp[3] = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_last = 0; out_ready = 0; in_r = '0; in_i = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            frame_err !== 1'b0 || out_r !== '0 || out_i !== '0)
            $display("FAIL reset_state rdy=%b vld=%b last=%b err=%b r=%0d i=%0d required 0",
                     in_ready, out_valid, out_last, frame_err, out_r, out_i);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
        else passed++;
    endtask

    task automatic test_roundtrip();
        xr = '{10, -2, -2, -2};
        xi = '{0, 2, 0, -2};
        set_last_ok();
        send(0);
        total++;
        if (out_valid !== 1'b0) $display("FAIL latency_t out_valid=%b required 0", out_valid);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1) $display("FAIL latency_t1 out_valid=%b required 1", out_valid);
        else passed++;
        for (int n = 0; n < 4; n++) pop(n);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (got_r[n] !== n + 1 || got_i[n] !== 0 || got_l[n] !== (n == 3))
                $display("FAIL roundtrip[%0d] got (%0d,%0d,last=%b) required (%0d,0,last=%b)",
                         n, got_r[n], got_i[n], got_l[n], n + 1, n == 3);
            else passed++;
        end
    endtask

    task automatic test_rounding();
        int vals [4];
        vals = '{4, 2, -2, 1};
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++) begin
                xr[k] = (t == 0 || k == 0) ? vals[t] : 0;
                xi[k] = 0;
            end
            ref_ifft();
            set_last_ok();
            send(0);
            for (int n = 0; n < 4; n++) pop(n);
            for (int n = 0; n < 4; n++) begin
                total++;
                if (got_r[n] !== ex_r[n] || got_i[n] !== ex_i[n] || got_l[n] !== (n == 3))
                    $display("FAIL rounding%0d[%0d] got (%0d,%0d) required (%0d,%0d)",
                             t, n, got_r[n], got_i[n], ex_r[n], ex_i[n]);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit pat [7];
        int idx;
        int k;
        pat = '{1, 0, 0, 1, 0, 1, 1};
        rand_frame();
        ref_ifft();
        set_last_ok();
        send(0);
        k = 0;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            out_ready = pat[c];
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                int'(out_r) !== ex_r[idx] || int'(out_i) !== ex_i[idx] ||
                out_last !== (idx == 3))
                $display("FAIL bp_cycle%0d vld=%b rdy=%b got (%0d,%0d,%b) required (%0d,%0d,%b)",
                         c, out_valid, in_ready, out_r, out_i, out_last,
                         ex_r[idx], ex_i[idx], idx == 3);
            else passed++;
            @(posedge clk); #1;
            if (pat[c]) idx++;
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_done out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_frame_err();
        push(5, 1, 0, 0);
        push(7, 7, 1, 0);
        total++;
        if (frame_err !== 1'b1) $display("FAIL ferr_short_pulse frame_err=%b required 1", frame_err);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (frame_err !== 1'b0) $display("FAIL ferr_short_width frame_err=%b required 0", frame_err);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL ferr_no_output out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
            else passed++;
            @(posedge clk); #1;
        end
        rand_frame();
        ref_ifft();
        set_last_ok();
        send(0);
        for (int n = 0; n < 4; n++) pop(n);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (got_r[n] !== ex_r[n] || got_i[n] !== ex_i[n] || got_l[n] !== (n == 3))
                $display("FAIL ferr_recover[%0d] got (%0d,%0d) required (%0d,%0d)",
                         n, got_r[n], got_i[n], ex_r[n], ex_i[n]);
            else passed++;
        end
        rand_frame();
        ref_ifft();
        lp = '{0, 0, 0, 0};
        send(0);
        total++;
        if (frame_err !== 1'b1) $display("FAIL ferr_nolast_pulse frame_err=%b required 1", frame_err);
        else passed++;
        for (int n = 0; n < 4; n++) pop(n);
        total++;
        if (frame_err !== 1'b0) $display("FAIL ferr_nolast_width frame_err=%b required 0", frame_err);
        else passed++;
        for (int n = 0; n < 4; n++) begin
            total++;
            if (got_r[n] !== ex_r[n] || got_i[n] !== ex_i[n] || got_l[n] !== (n == 3))
                $display("FAIL ferr_nolast[%0d] got (%0d,%0d) required (%0d,%0d)",
                         n, got_r[n], got_i[n], ex_r[n], ex_i[n]);
            else passed++;
        end
    endtask

    task automatic test_extremes();
        int v [2];
        v = '{-(1 << (W - 1)), (1 << (W - 1)) - 1};
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 4; k++) begin
                xr[k] = v[t];
                xi[k] = v[t];
            end
            ref_ifft();
            set_last_ok();
            send(0);
            for (int n = 0; n < 4; n++) pop(n);
            for (int n = 0; n < 4; n++) begin
                total++;
                if (got_r[n] !== ex_r[n] || got_i[n] !== ex_i[n])
                    $display("FAIL extreme%0d[%0d] got (%0d,%0d) required (%0d,%0d)",
                             t, n, got_r[n], got_i[n], ex_r[n], ex_i[n]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_frame();
        set_last_ok();
        send(0);
        pop(0);
        pop(1);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_r !== '0)
            $display("FAIL rst_mid out_valid=%b in_ready=%b out_r=%0d required 0/0/0",
                     out_valid, in_ready, out_r);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_mid_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passed++;
        rand_frame();
        ref_ifft();
        send(0);
        for (int n = 0; n < 4; n++) pop(n);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (got_r[n] !== ex_r[n] || got_i[n] !== ex_i[n] || got_l[n] !== (n == 3))
                $display("FAIL rst_fresh[%0d] got (%0d,%0d) required (%0d,%0d)",
                         n, got_r[n], got_i[n], ex_r[n], ex_i[n]);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            ref_ifft();
            set_last_ok();
            send(1);
            for (int n = 0; n < 4; n++) pop(n);
            for (int n = 0; n < 4; n++) begin
                total++;
                if (got_r[n] !== ex_r[n] || got_i[n] !== ex_i[n] || got_l[n] !== (n == 3))
                    $display("FAIL random%0d[%0d] got (%0d,%0d,%b) required (%0d,%0d,%b)",
                             f, n, got_r[n], got_i[n], got_l[n], ex_r[n], ex_i[n], n == 3);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_roundtrip();
        test_rounding();
        test_backpressure();
        test_frame_err();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
